// File: rtl/sseg_pkg.sv
// Shared types, select codes and helpers for the 7-segment display scanner.
package sseg_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } sseg_scan_state_t;

  localparam logic [3:0] SEL_DIGIT0 = 4'b1110;
  localparam logic [3:0] SEL_DIGIT1 = 4'b1101;
  localparam logic [3:0] SEL_DIGIT2 = 4'b1011;
  localparam logic [3:0] SEL_DIGIT3 = 4'b0111;
  localparam logic [3:0] SEL_NONE   = 4'b1111;

  // Active-low one-hot select for a digit index.
  function automatic logic [3:0] sel_of(input logic [1:0] idx);
    case (idx)
      2'd0:    sel_of = SEL_DIGIT0;
      2'd1:    sel_of = SEL_DIGIT1;
      2'd2:    sel_of = SEL_DIGIT2;
      default: sel_of = SEL_DIGIT3;
    endcase
  endfunction

  // Digit k is a leading zero when it and every higher digit are zero.
  // z[j] is set when digit j is zero; digit 0 is always shown.
  function automatic logic lead_zero(input logic [1:0] k, input logic [3:1] z);
    case (k)
      2'd3:    lead_zero = z[3];
      2'd2:    lead_zero = z[3] & z[2];
      2'd1:    lead_zero = &z;
      default: lead_zero = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sseg_scan_if.sv
// Digit data in, scan select / anode drive and ticks out.
interface sseg_scan_if;
  logic       en;
  logic [3:0] bcd0;
  logic [3:0] bcd1;
  logic [3:0] bcd2;
  logic [3:0] bcd3;
  logic [3:0] sel;
  logic [3:0] an;
  logic       digit_tick;
  logic       frame_tick;

  modport master (
    output en, bcd0, bcd1, bcd2, bcd3,
    input  sel, an, digit_tick, frame_tick
  );

  modport slave (
    input  en, bcd0, bcd1, bcd2, bcd3,
    output sel, an, digit_tick, frame_tick
  );
endinterface

// File: rtl/sseg_slot_timer.sv
// Per-slot cycle counter. Runs only while the scanner is active and wraps
// every DIGIT_CYCLES; strobes are decoded from the current count.
module sseg_slot_timer #(
  parameter int DIGIT_CYCLES = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic run,
  output logic slot_start,
  output logic blank_end,
  output logic slot_end
);
  localparam int CNT_W = $clog2(DIGIT_CYCLES);

  logic [CNT_W-1:0] cnt;

  assign slot_start = run && (cnt == '0);
  assign blank_end  = run && (cnt == CNT_W'(BLANK_CYCLES - 1));
  assign slot_end   = run && (cnt == CNT_W'(DIGIT_CYCLES - 1));

  // Count while running, clear when disabled or idle, wrap at slot end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!en || !run || slot_end)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/sseg_scan.sv
// 4-digit 7-segment scanner: rotates the digit select and gates the anodes
// with a dead-time window at the start of each slot.
// Optional leading-zero blanking: define SSEG_LZ_BLANK_EN.
//
// state   | meaning
// S_IDLE  | en low, display dark, select parked on digit 0
// S_BLANK | start of slot, anodes off while the BCD mux settles
// S_DRIVE | remainder of slot, anodes follow sel
module sseg_scan #(
  parameter int DIGIT_CYCLES = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input logic        clk,
  input logic        rst_n,
  sseg_scan_if.slave bus
);
  import sseg_pkg::*;

  sseg_scan_state_t state, state_n;
  logic [1:0]       idx, idx_n;
  logic [3:0]       sel_q, an_q, an_n;
  logic             dtick_q, ftick_q, dtick_n, ftick_n;
  logic             suppress_n;
  logic             blank_end, slot_end, slot_start_unused;

  sseg_slot_timer #(
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (bus.en),
    .run       (state != S_IDLE),
    .slot_start(slot_start_unused),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

  // Next state, digit rotation and tick generation; disable has priority.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    dtick_n = 1'b0;
    ftick_n = 1'b0;
    if (!bus.en) begin
      state_n = S_IDLE;
      idx_n   = 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_BLANK;
          idx_n   = 2'd0;
          dtick_n = 1'b1;
          ftick_n = 1'b1;
        end
        S_BLANK, S_DRIVE: begin
          if (slot_end) begin
            state_n = S_BLANK;
            idx_n   = idx + 2'd1;
            dtick_n = 1'b1;
            ftick_n = (idx_n == 2'd0);
          end else if (blank_end) begin
            state_n = S_DRIVE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

`ifdef SSEG_LZ_BLANK_EN
  logic       suppress;
  logic [3:1] bcd_zero;
  logic       unused_bcd0;

  assign bcd_zero    = {bus.bcd3 == 4'd0, bus.bcd2 == 4'd0, bus.bcd1 == 4'd0};
  assign unused_bcd0 = ^bus.bcd0;

  // Blanking decision is taken once, on the edge that opens a slot.
  always_comb begin
    suppress_n = suppress;
    if (!bus.en || state == S_IDLE)
      suppress_n = 1'b0;
    else if (slot_end)
      suppress_n = lead_zero(idx_n, bcd_zero);
  end

  // Hold the per-slot blanking decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      suppress <= 1'b0;
    else
      suppress <= suppress_n;
  end
`else
  logic unused_bcd;

  assign suppress_n = 1'b0;
  assign unused_bcd = ^{bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
`endif

  // Anodes follow the select only while driving an unsuppressed slot.
  always_comb begin
    an_n = SEL_NONE;
    if (state_n == S_DRIVE && !suppress_n)
      an_n = sel_of(idx_n);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= 2'd0;
      sel_q   <= SEL_DIGIT0;
      an_q    <= SEL_NONE;
      dtick_q <= 1'b0;
      ftick_q <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      sel_q   <= sel_of(idx_n);
      an_q    <= an_n;
      dtick_q <= dtick_n;
      ftick_q <= ftick_n;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.an         = an_q;
  assign bus.digit_tick = dtick_q;
  assign bus.frame_tick = ftick_q;
endmodule

// File: tb/tb_sseg_scan.sv
// Bench for sseg_scan with DIGIT_CYCLES=8, BLANK_CYCLES=2. The reference
// model tracks cycles since enable and derives slot/digit/position by
// division; leading-zero blanking is modelled when SSEG_LZ_BLANK_EN is set.
module tb_sseg_scan;
  localparam int DC = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  int   t = -1;
  logic sup_m = 1'b0;
  logic [3:0] exp_sel, exp_an;
  logic       exp_dt, exp_ft;

  sseg_scan_if bus ();

  sseg_scan #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  function automatic int cur_idx();
    return (t < 0) ? 0 : (t / DC) % 4;
  endfunction

  function automatic int cur_pos();
    return (t < 0) ? 0 : t % DC;
  endfunction

  task automatic model_expect();
    int idx, pos;
    idx = cur_idx();
    pos = cur_pos();
    if (t < 0) begin
      exp_sel = 4'b1110;
      exp_an  = 4'b1111;
      exp_dt  = 1'b0;
      exp_ft  = 1'b0;
    end else begin
      exp_sel = ~(4'b0001 << idx);
      exp_dt  = (pos == 0);
      exp_ft  = (pos == 0) && (idx == 0);
      exp_an  = (pos >= BC && !sup_m) ? exp_sel : 4'b1111;
    end
  endtask

  task automatic compare_all(input string tag);
    model_expect();
    chk({tag, ".sel"}, bus.sel, exp_sel);
    chk({tag, ".an"}, bus.an, exp_an);
    chk({tag, ".dtick"}, {3'b000, bus.digit_tick}, {3'b000, exp_dt});
    chk({tag, ".ftick"}, {3'b000, bus.frame_tick}, {3'b000, exp_ft});
  endtask

  // One clock edge: capture inputs seen at the edge, advance the model, check.
  task automatic step(input string tag);
    logic       en_s, rst_s;
    logic [3:0] b[4];
    int         idx;
    en_s = bus.en;
    b[0] = bus.bcd0; b[1] = bus.bcd1; b[2] = bus.bcd2; b[3] = bus.bcd3;
    @(posedge clk);
    rst_s = rst_n;
    #1;
    if (!rst_s || !en_s) t = -1;
    else t = t + 1;
    if (t >= 0 && cur_pos() == 0) begin
      idx   = cur_idx();
      sup_m = 1'b0;
`ifdef SSEG_LZ_BLANK_EN
      if (idx != 0) begin
        sup_m = 1'b1;
        for (int j = idx; j < 4; j++)
          if (b[j] != 4'd0) sup_m = 1'b0;
      end
`endif
    end
    compare_all(tag);
  endtask

  task automatic set_bcd(input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, input logic [3:0] d0);
    bus.bcd3 = d3; bus.bcd2 = d2; bus.bcd1 = d1; bus.bcd0 = d0;
  endtask

  function automatic logic [3:0] rand_digit();
    return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
  endfunction

  initial begin
    logic found;
    rst_n  = 1'b0;
    bus.en = 1'b1;
    set_bcd(4'd0, 4'd0, 4'd4, 4'd7);

    repeat (5) step("reset");
    rst_n = 1'b1;

    repeat (80) step("scan");

    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (cur_idx() == 2 && cur_pos() == 3) found = 1'b1;
      else step("seek_d2");
    end
    chk("reach_digit2", {3'b000, found}, 4'b0001);
    bus.en = 1'b0;
    repeat (3) step("disabled");
    bus.en = 1'b1;
    repeat (12) step("reenable");

    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (cur_pos() == BC + 1) found = 1'b1;
      else step("seek_drive");
    end
    chk("reach_drive", {3'b000, found}, 4'b0001);
    rst_n = 1'b0;
    t     = -1;
    #1;
    compare_all("async_rst");
    #1;
    rst_n = 1'b1;
    repeat (20) step("post_rst");

    set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (40) step("all_zero");

    set_bcd(4'd0, 4'd0, 4'd4, 4'd7);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (cur_idx() == 3 && cur_pos() == 4) found = 1'b1;
      else step("seek_d3");
    end
    chk("reach_digit3", {3'b000, found}, 4'b0001);
    bus.bcd3 = 4'd5;
    repeat (40) step("bcd3_change");

    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 39) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 9) == 0)
        set_bcd(rand_digit(), rand_digit(), rand_digit(), rand_digit());
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
